// File: rtl/tic_tac_toe_nxn_pkg.sv
// Shared encodings for the N x N tic-tac-toe controller: cell codes and FSM states.
package tic_tac_toe_pkg;

  localparam logic [1:0] CELL_EMPTY    = 2'b00;
  localparam logic [1:0] CELL_PLAYER   = 2'b01;
  localparam logic [1:0] CELL_COMPUTER = 2'b10;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_PLAYER   = 4'b0010,
    ST_COMPUTER = 4'b0100,
    ST_DONE     = 4'b1000
  } state_t;

endpackage

// File: rtl/tic_tac_toe_nxn_if.sv
// Move-entry / board-driver bundle for tic_tac_toe_nxn.
// The master side is the keypad/AI engine; the slave side is the game controller.
interface tic_tac_toe_nxn_if #(
  parameter int N = 3
);
  localparam int CELLS  = N * N;
  localparam int ADDR_W = $clog2(CELLS);
  localparam int MC_W   = $clog2(CELLS + 1);

  logic                new_game;
  logic                player_move;
  logic                computer_move;
  logic [ADDR_W-1:0]   player_address;
  logic [ADDR_W-1:0]   computer_address;
  logic [2*CELLS-1:0]  board;
  logic                turn;
  logic [MC_W-1:0]     move_count;
  logic                win;
  logic                winner;
  logic                draw;
  logic                illegal_move;

  modport master (
    output new_game, player_move, computer_move, player_address, computer_address,
    input  board, turn, move_count, win, winner, draw, illegal_move
  );

  modport slave (
    input  new_game, player_move, computer_move, player_address, computer_address,
    output board, turn, move_count, win, winner, draw, illegal_move
  );
endinterface

// File: rtl/tic_tac_toe_nxn_line_checker.sv
// Combinational line detector: flags a side owning any full row, column or diagonal.
module ttt_line_checker
  import tic_tac_toe_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [2*N*N-1:0] board,
  output logic             player_line,
  output logic             computer_line
);

  // Scan all rows, columns and both diagonals for N equal owned cells.
  always_comb begin : scan
    logic row_p, row_c, col_p, col_c, dia_p, dia_c, ant_p, ant_c;
    player_line   = 1'b0;
    computer_line = 1'b0;
    dia_p = 1'b1;
    dia_c = 1'b1;
    ant_p = 1'b1;
    ant_c = 1'b1;
    for (int unsigned r = 0; r < N; r++) begin
      row_p = 1'b1;
      row_c = 1'b1;
      col_p = 1'b1;
      col_c = 1'b1;
      for (int unsigned c = 0; c < N; c++) begin
        row_p &= (board[2*(r*N+c) +: 2] == CELL_PLAYER);
        row_c &= (board[2*(r*N+c) +: 2] == CELL_COMPUTER);
        col_p &= (board[2*(c*N+r) +: 2] == CELL_PLAYER);
        col_c &= (board[2*(c*N+r) +: 2] == CELL_COMPUTER);
      end
      player_line   |= row_p | col_p;
      computer_line |= row_c | col_c;
      dia_p &= (board[2*(r*N+r) +: 2] == CELL_PLAYER);
      dia_c &= (board[2*(r*N+r) +: 2] == CELL_COMPUTER);
      ant_p &= (board[2*(r*N+N-1-r) +: 2] == CELL_PLAYER);
      ant_c &= (board[2*(r*N+N-1-r) +: 2] == CELL_COMPUTER);
    end
    player_line   |= dia_p | ant_p;
    computer_line |= dia_c | ant_c;
  end

endmodule

// File: rtl/tic_tac_toe_nxn.sv
// N x N tic-tac-toe game controller: arbitrates alternating moves, flags
// illegal moves and reports win/draw on the same edge that accepts a move.
module tic_tac_toe_nxn
  import tic_tac_toe_pkg::*;
#(
  parameter int N           = 3,
  parameter bit FIRST_MOVER = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  tic_tac_toe_nxn_if.slave     bus
);

  localparam int CELLS = N * N;
  localparam int MC_W  = $clog2(CELLS + 1);

  state_t             state;
  logic [2*CELLS-1:0] board_q;
  logic [2*CELLS-1:0] board_nxt;
  logic [MC_W-1:0]    count_q;
  logic               turn_q, win_q, winner_q, draw_q, illegal_q;
  logic               p_free, c_free, p_ok, c_ok, p_line, c_line, last_cell;

  // Move legality and the board as it would look after this edge.
  // Out-of-range addresses never match a cell index, so they are never "free".
  always_comb begin
    p_free    = 1'b0;
    c_free    = 1'b0;
    board_nxt = board_q;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (32'(bus.player_address) == i && board_q[2*i +: 2] == CELL_EMPTY)
        p_free = 1'b1;
      if (32'(bus.computer_address) == i && board_q[2*i +: 2] == CELL_EMPTY)
        c_free = 1'b1;
    end
    p_ok = (state == ST_PLAYER) && bus.player_move && p_free;
    c_ok = (state == ST_COMPUTER) && bus.computer_move && c_free;
    for (int unsigned i = 0; i < CELLS; i++) begin
      if (p_ok && 32'(bus.player_address) == i)
        board_nxt[2*i +: 2] = CELL_PLAYER;
      if (c_ok && 32'(bus.computer_address) == i)
        board_nxt[2*i +: 2] = CELL_COMPUTER;
    end
    last_cell = (32'(count_q) + 32'd1 == 32'(CELLS));
  end

  ttt_line_checker #(.N(N)) u_lines (
    .board         (board_nxt),
    .player_line   (p_line),
    .computer_line (c_line)
  );

  // Game FSM with registered outputs; rst and new_game clear identically.
  always_ff @(posedge clk) begin
    if (rst || bus.new_game) begin
      state     <= ST_IDLE;
      board_q   <= '0;
      count_q   <= '0;
      turn_q    <= FIRST_MOVER;
      win_q     <= 1'b0;
      winner_q  <= 1'b0;
      draw_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= (bus.player_move && !p_ok) || (bus.computer_move && !c_ok);
      case (state)
        ST_IDLE: state <= FIRST_MOVER ? ST_PLAYER : ST_COMPUTER;
        ST_PLAYER, ST_COMPUTER: begin
          if (p_ok || c_ok) begin
            board_q <= board_nxt;
            if (count_q != MC_W'(CELLS))
              count_q <= count_q + 1'b1;
            // Only the mover can complete a line, so a win on the last cell beats draw.
            if ((p_ok && p_line) || (c_ok && c_line)) begin
              win_q    <= 1'b1;
              winner_q <= p_ok;
              state    <= ST_DONE;
            end else if (last_cell) begin
              draw_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              turn_q <= c_ok;
              state  <= p_ok ? ST_COMPUTER : ST_PLAYER;
            end
          end
        end
        ST_DONE: state <= ST_DONE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.board        = board_q;
  assign bus.turn         = turn_q;
  assign bus.move_count   = count_q;
  assign bus.win          = win_q;
  assign bus.winner       = winner_q;
  assign bus.draw         = draw_q;
  assign bus.illegal_move = illegal_q;

endmodule

// File: doc/tic_tac_toe_nxn.md
Name: tic_tac_toe_nxn

Overview:
Parametrised successor to the fixed 3x3 game controller.
- Holds an N x N board and arbitrates alternating player/computer moves.
- Flags illegal moves and detects win (full row, column or either diagonal of length N) or draw.
- Adds: configurable board size and first mover, a soft new_game restart, a move counter and a turn indicator.
- Sits between the move-entry logic (keypad/AI engine) and the LED board driver.

Parameters:
- N, 3, board side length (3..8).
- CELLS, N*N, derived; number of cells.
- ADDR_W, $clog2(N*N), derived; move address width.
- FIRST_MOVER, 1, side that moves first after reset/new_game (1 = player, 0 = computer).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- new_game  in  1  synchronous soft restart: clears board and flags, keeps parameters.
- player_move  in  1  player move strobe, one cycle.
- computer_move  in  1  computer move strobe, one cycle.
- player_address  in  ADDR_W  cell index of player move (row-major, 0 = top-left).
- computer_address  in  ADDR_W  cell index of computer move.
- board  out  2*CELLS  cell state, cell i at bits [2i+1:2i]; 00 empty, 01 player, 10 computer.
- turn  out  1  1 = player to move, 0 = computer to move (valid in PLAY states).
- move_count  out  $clog2(CELLS+1)  number of accepted moves.
- win  out  1  game won (level, held in DONE).
- winner  out  1  1 = player won, 0 = computer won; valid only when win = 1.
- draw  out  1  board full with no win (level, held in DONE).
- illegal_move  out  1  one-cycle pulse on a rejected move strobe.

Behaviour:
Reset
- rst = 1 at a clock edge: board all 00, move_count 0, win/winner/draw/illegal_move 0, state ST_IDLE, turn = FIRST_MOVER.
- rst has priority over new_game and over every move.
- new_game = 1 (rst = 0): same clearing effect as rst in the same cycle; any move strobes that cycle are ignored and do not flag illegal.

States
- ST_IDLE -> ST_PLAYER (FIRST_MOVER = 1) or ST_COMPUTER (FIRST_MOVER = 0) unconditionally on the next edge.
- ST_PLAYER: accepts only player_move.
- ST_COMPUTER: accepts only computer_move.
- ST_DONE: terminal; left only by rst or new_game.

Moves
- In ST_IDLE, any move strobe is rejected: illegal_move = 1 for one cycle, board unchanged.
- A move is accepted iff all hold:
  - the state is the mover's turn state;
  - address < CELLS;
  - the target cell is 00.
- Accepted move, latency 1:
  - after that edge the cell holds the mover's code and move_count increments;
  - win/draw reflect the updated board;
  - state goes to the other side's turn state, or ST_DONE.
- Win/draw evaluation uses the next-board value, so there is no extra cycle.
- Rejected move:
  - illegal_move = 1 for exactly the following cycle;
  - board, turn, move_count and state are unchanged;
  - the same side retries.
- Both strobes high in one cycle: the on-turn side's move is evaluated normally and the off-turn strobe is rejected. illegal_move = 1 if either strobe is rejected.
- Causes of rejection:
  - out-of-range address (e.g. 9..15 for N = 3);
  - occupied cell;
  - wrong turn;
  - any move strobe in ST_DONE.

End of game
- Win: any complete row, column, main or anti-diagonal holding N equal non-empty codes.
  - Sets win = 1, winner = mover, and moves to ST_DONE.
- Draw: move_count reaches CELLS with no win.
  - Sets draw = 1 and moves to ST_DONE.
- A win on the final cell has priority: win = 1, draw = 0.
- win, winner and draw hold until rst or new_game.
- turn freezes in ST_DONE.
- move_count saturates at CELLS and never wraps.

Decomposition:
- Package tic_tac_toe_pkg holds:
  - cell encodings CELL_EMPTY = 2'b00, CELL_PLAYER = 2'b01, CELL_COMPUTER = 2'b10;
  - one-hot state encodings ST_IDLE = 4'b0001, ST_PLAYER = 4'b0010, ST_COMPUTER = 4'b0100, ST_DONE = 4'b1000.
  - Cell and state constants use distinct names.
- Sub-module ttt_line_checker (parameter N): purely combinational. Input is the flat board. Outputs are player_line and computer_line, each asserted if that side owns any full row, column or diagonal.
- The top instantiates one ttt_line_checker on the next-board value.

Test Plan:
All scenarios use N = 3 and FIRST_MOVER = 1 unless stated.
1. Reset, then player cells 0, 4, 8 interleaved with computer cells 1, 2. After the 5th accepted move: win = 1, winner = 1, draw = 0, state ST_DONE, move_count = 5.
2. Player 0, then player_move again at 1 (wrong turn): illegal_move pulses one cycle, board unchanged, turn = 0. Then computer 0 (occupied): illegal_move pulses again. Then computer 9 (out of range): illegal_move pulses again.
3. Full-board draw:
   - Sequence P0, C1, P2, C4, P3, C5, P7, C6, P8.
   - After the 9th move: draw = 1, win = 0, move_count = 9.
   - A further player_move yields illegal_move and no change.
4. Both strobes in one cycle during the player turn (player 4, computer 5): cell 4 = 01, cell 5 = 00, illegal_move = 1, turn = 0.
5. Reset behaviour:
   - new_game mid-game (after 3 moves, with move strobes the same cycle): board all 00, move_count 0, no illegal_move pulse; play resumes from ST_IDLE.
   - rst asserted together with new_game and a move: all outputs at reset values.
6. N = 4, FIRST_MOVER = 0: computer cells 3, 6, 9, 12 (anti-diagonal) interleaved with player cells 0, 1, 2. After the 7th move: win = 1, winner = 0.
